// File: rtl/vga_timing_pkg.sv
// Shared types, 640x480@60 default constants and helpers for the VGA raster timing generator.
package vga_timing_pkg;

  typedef enum logic [1:0] {
    PH_ACTIVE = 2'd0,
    PH_FRONT  = 2'd1,
    PH_SYNC   = 2'd2,
    PH_BACK   = 2'd3
  } phase_t;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;
  localparam int DEF_CNT_W    = 10;

  function automatic int total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Phase of a position along one axis; the back porch runs to the end of the axis.
  function automatic phase_t phase_of(input int c, input int active, input int fp, input int sync);
    phase_t ph;
    if (c < active) begin
      ph = PH_ACTIVE;
    end else if (c < active + fp) begin
      ph = PH_FRONT;
    end else if (c < active + fp + sync) begin
      ph = PH_SYNC;
    end else begin
      ph = PH_BACK;
    end
    return ph;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with its phase registered alongside,
// so phase always describes the count shown in the same cycle.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int ACTIVE = DEF_H_ACTIVE,
  parameter int FP     = DEF_H_FP,
  parameter int SYNC   = DEF_H_SYNC,
  parameter int BP     = DEF_H_BP,
  parameter int W      = DEF_CNT_W
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         step,
  output logic [W-1:0] count,
  output phase_t       phase,
  output logic         wrap
);

  localparam int         TOTAL = total(ACTIVE, FP, SYNC, BP);
  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  logic [W-1:0] count_next_s;

  assign wrap = (count == LAST);

  // Next position along the axis.
  always_comb begin
    count_next_s = '0;
    if (wrap) begin
      count_next_s = '0;
    end else begin
      count_next_s = count + W'(1);
    end
  end

  // Position and phase registers, advanced together on step.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= LAST;
      phase <= PH_BACK;
    end else if (step) begin
      count <= count_next_s;
      phase <= phase_of(32'(count_next_s), ACTIVE, FP, SYNC);
    end
  end

endmodule

// File: rtl/vga_timing_generator.sv
// Parametrised VGA raster timing source with registered, zero-lag decoded outputs.
// Optional feature: define VGA_FRAME_COUNT_EN to add the 16-bit frame_count output.
module vga_timing_generator
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter int HS_POL   = 0,
  parameter int VS_POL   = 0,
  parameter int CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             pix_en,
  output logic [CNT_W-1:0] h_count,
  output logic [CNT_W-1:0] v_count,
  output phase_t           h_phase,
  output phase_t           v_phase,
  output logic             hsync,
  output logic             vsync,
  output logic             active,
  output logic             line_start,
  output logic             frame_start
`ifdef VGA_FRAME_COUNT_EN
  ,
  output logic [15:0]      frame_count
`endif
);

  localparam int     H_TOTAL = total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int     V_TOTAL = total(V_ACTIVE, V_FP, V_SYNC, V_BP);
  localparam longint CNT_CAP = longint'(1) << CNT_W;
  localparam logic   HS_ON   = (HS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic   VS_ON   = (VS_POL != 0) ? 1'b1 : 1'b0;
  localparam logic [CNT_W-1:0] H_ACT_C = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_C = CNT_W'(V_ACTIVE);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_bad_timing
    $error("vga_timing_generator: every timing parameter must be at least 1");
  end
  if (CNT_CAP < longint'(H_TOTAL) || CNT_CAP < longint'(V_TOTAL)) begin : g_bad_width
    $error("vga_timing_generator: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end

  logic             h_wrap_s;
  logic             v_wrap_s;
  logic             v_step_s;
  logic [CNT_W-1:0] h_next_s;
  logic [CNT_W-1:0] v_next_s;

  assign v_step_s = pix_en & h_wrap_s;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE), .FP (H_FP), .SYNC (H_SYNC), .BP (H_BP), .W (CNT_W)
  ) u_h_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (pix_en),
    .count   (h_count),
    .phase   (h_phase),
    .wrap    (h_wrap_s)
  );

  vga_axis_counter #(
    .ACTIVE (V_ACTIVE), .FP (V_FP), .SYNC (V_SYNC), .BP (V_BP), .W (CNT_W)
  ) u_v_axis (
    .clk     (clk),
    .reset_n (reset_n),
    .step    (v_step_s),
    .count   (v_count),
    .phase   (v_phase),
    .wrap    (v_wrap_s)
  );

  // Position the counters move to on a pixel step; decoding it keeps outputs zero-lag.
  always_comb begin
    h_next_s = h_count;
    v_next_s = v_count;
    if (h_wrap_s) begin
      h_next_s = '0;
      if (v_wrap_s) begin
        v_next_s = '0;
      end else begin
        v_next_s = v_count + CNT_W'(1);
      end
    end else begin
      h_next_s = h_count + CNT_W'(1);
      v_next_s = v_count;
    end
  end

  // Sync levels, active flag and one-clock strobes; strobes clear even without pix_en.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hsync       <= ~HS_ON;
      vsync       <= ~VS_ON;
      active      <= 1'b0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      if (pix_en) begin
        hsync       <= (phase_of(32'(h_next_s), H_ACTIVE, H_FP, H_SYNC) == PH_SYNC) ? HS_ON : ~HS_ON;
        vsync       <= (phase_of(32'(v_next_s), V_ACTIVE, V_FP, V_SYNC) == PH_SYNC) ? VS_ON : ~VS_ON;
        active      <= (h_next_s < H_ACT_C) && (v_next_s < V_ACT_C);
        line_start  <= h_wrap_s;
        frame_start <= h_wrap_s & v_wrap_s;
      end
    end
  end

`ifdef VGA_FRAME_COUNT_EN
  // Frames started since reset, updated on the same edge that raises frame_start.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count <= 16'd0;
    end else if (pix_en & h_wrap_s & v_wrap_s) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing_generator.sv
// Self-checking bench: a pixel-index raster model checked every cycle against a
// default 640x480 instance and a tiny inverted-polarity instance, plus literal pins.
module tb_vga_timing_generator;
  import vga_timing_pkg::*;

  localparam int D_HT = 800, D_VT = 525;
  localparam int S_HT = 7,   S_VT = 6;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  logic pix_en = 1'b0;

  logic [9:0] d_h, d_v;
  phase_t     d_hp, d_vp;
  logic       d_hs, d_vs, d_act, d_ls, d_fs;
  logic [3:0] s_h, s_v;
  phase_t     s_hp, s_vp;
  logic       s_hs, s_vs, s_act, s_ls, s_fs;
`ifdef VGA_FRAME_COUNT_EN
  logic [15:0] d_fc, s_fc;
`endif

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  vga_timing_generator u_dflt (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .h_count(d_h), .v_count(d_v), .h_phase(d_hp), .v_phase(d_vp),
    .hsync(d_hs), .vsync(d_vs), .active(d_act),
    .line_start(d_ls), .frame_start(d_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(d_fc)
`endif
  );

  vga_timing_generator #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1), .VS_POL(1), .CNT_W(4)
  ) u_small (
    .clk(clk), .reset_n(reset_n), .pix_en(pix_en),
    .h_count(s_h), .v_count(s_v), .h_phase(s_hp), .v_phase(s_vp),
    .hsync(s_hs), .vsync(s_vs), .active(s_act),
    .line_start(s_ls), .frame_start(s_fs)
`ifdef VGA_FRAME_COUNT_EN
    , .frame_count(s_fc)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: pixel steps taken since reset, and whether the last edge stepped.
  longint k = 0;
  bit     stepped = 1'b0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      k <= 0;
      stepped <= 1'b0;
    end else begin
      stepped <= pix_en;
      if (pix_en) k <= k + 1;
    end
  end

  function automatic int seg(input int c, input int a, input int f, input int s);
    if (c < a) return 0;
    if (c < a + f) return 1;
    if (c < a + f + s) return 2;
    return 3;
  endfunction

  // Raster position is pixel index (k-1) modulo frame size; reset shows the last pixel.
  task automatic model_check(input string tag, input int ha, input int hf, input int hsw, input int ht,
                             input int va, input int vf, input int vsw, input int vt,
                             input bit hon, input bit von,
                             input logic [31:0] ah, input logic [31:0] av,
                             input logic [31:0] ahp, input logic [31:0] avp,
                             input logic ahs, input logic avs, input logic aact,
                             input logic als, input logic afs);
    longint pt, p;
    int h, v;
    pt = longint'(ht) * vt;
    p  = (pt - 1 + k) % pt;
    h  = int'(p % ht);
    v  = int'(p / ht);
    check({tag, "_h_count"}, ah, h);
    check({tag, "_v_count"}, av, v);
    check({tag, "_h_phase"}, ahp, seg(h, ha, hf, hsw));
    check({tag, "_v_phase"}, avp, seg(v, va, vf, vsw));
    check({tag, "_hsync"}, 32'(ahs), 32'((seg(h, ha, hf, hsw) == 2) ? hon : !hon));
    check({tag, "_vsync"}, 32'(avs), 32'((seg(v, va, vf, vsw) == 2) ? von : !von));
    check({tag, "_active"}, 32'(aact), 32'(k > 0 && h < ha && v < va));
    check({tag, "_line_start"}, 32'(als), 32'(stepped && h == 0));
    check({tag, "_frame_start"}, 32'(afs), 32'(stepped && p == 0));
  endtask

  // Single compare process: every cycle, both instances against the model.
  always @(negedge clk) begin
    model_check("d", 640, 16, 96, D_HT, 480, 10, 2, D_VT, 1'b0, 1'b0,
                32'(d_h), 32'(d_v), 32'(d_hp), 32'(d_vp), d_hs, d_vs, d_act, d_ls, d_fs);
    model_check("s", 4, 1, 1, S_HT, 3, 1, 1, S_VT, 1'b1, 1'b1,
                32'(s_h), 32'(s_v), 32'(s_hp), 32'(s_vp), s_hs, s_vs, s_act, s_ls, s_fs);
`ifdef VGA_FRAME_COUNT_EN
    check("d_frame_count", 32'(d_fc), 32'(((k + D_HT * D_VT - 1) / (D_HT * D_VT)) % 65536));
    check("s_frame_count", 32'(s_fc), 32'(((k + S_HT * S_VT - 1) / (S_HT * S_VT)) % 65536));
`endif
  end

  task automatic step(input bit en);
    pix_en = en;
    @(negedge clk);
    cyc++;
  endtask

  task automatic check_reset_literals(input string tag);
    check({tag, "_d_h"}, 32'(d_h), 32'd799);
    check({tag, "_d_v"}, 32'(d_v), 32'd524);
    check({tag, "_d_hsync"}, 32'(d_hs), 32'd1);
    check({tag, "_d_vsync"}, 32'(d_vs), 32'd1);
    check({tag, "_d_active"}, 32'(d_act), 32'd0);
    check({tag, "_d_strobes"}, {30'd0, d_ls, d_fs}, 32'd0);
    check({tag, "_s_h"}, 32'(s_h), 32'd6);
    check({tag, "_s_hsync"}, 32'(s_hs), 32'd0);
  endtask

  initial begin
    int hlow, svhi, s_last, d_last, nfs;
    hlow = 0; svhi = 0; s_last = -1; d_last = -1; nfs = 0;

    reset_n = 1'b0;
    repeat (3) step(1'b0);
    check_reset_literals("rst");
    reset_n = 1'b1;
    step(1'b0);
    check_reset_literals("rst_hold");

    // Continuous pixel enable: two default lines and many tiny frames.
    for (int i = 1; i <= 1700; i++) begin
      step(1'b1);
      if (i == 1) begin
        check("first_h", 32'(d_h), 32'd0);
        check("first_v", 32'(d_v), 32'd0);
        check("first_active", 32'(d_act), 32'd1);
        check("first_fs", 32'(d_fs), 32'd1);
        check("first_ls", 32'(d_ls), 32'd1);
      end
      if (i == 2) check("second_strobes", {30'd0, d_ls, d_fs}, 32'd0);
      if (i == 640) check("act_h639", 32'(d_act), 32'd1);
      if (i == 641) check("act_h640", 32'(d_act), 32'd0);
      if (i == 656) check("hs_h655", 32'(d_hs), 32'd1);
      if (i == 657) check("hs_h656", 32'(d_hs), 32'd0);
      if (i == 752) check("hs_h751", 32'(d_hs), 32'd0);
      if (i == 753) check("hs_h752", 32'(d_hs), 32'd1);
      if (i == 800) check("h_last", 32'(d_h), 32'd799);
      if (i == 801) check("wrap_line", {d_v[5:0], d_h, 15'd0, d_ls}, {6'd1, 10'd0, 15'd0, 1'b1});
      if (i <= 800 && d_hs == 1'b0) hlow++;
      if (i <= 42 && s_vs == 1'b1) svhi++;
      if (s_fs) begin
        nfs++;
        if (s_last >= 0) check("s_frame_period", cyc - s_last, 32'd42);
        s_last = cyc;
`ifdef VGA_FRAME_COUNT_EN
        if (nfs <= 3) check("s_fc_seq", 32'(s_fc), nfs);
`endif
      end
    end
    check("hsync_low_len", hlow, 32'd96);
    check("s_vsync_high_len", svhi, 32'd7);

    // pix_en 1/0/0: everything advances once per three clocks.
    s_last = -1;
    for (int j = 0; j < 7500; j++) begin
      step(j % 3 == 0);
      if (s_fs) begin
        if (s_last >= 0) check("s_frame_period_div3", cyc - s_last, 32'd126);
        s_last = cyc;
      end
      if (d_ls) begin
        if (d_last >= 0) check("d_line_period_div3", cyc - d_last, 32'd2400);
        d_last = cyc;
      end
    end

    // Asynchronous reset mid-frame.
    reset_n = 1'b0;
    step(1'b0);
    reset_n = 1'b1;
    step(1'b0);
    repeat (1901) step(1'b1);
    check("pre_reset_h", 32'(d_h), 32'd300);
    check("pre_reset_v", 32'(d_v), 32'd2);
    #2 reset_n = 1'b0;
    #1 check_reset_literals("async");
    @(negedge clk);
    reset_n = 1'b1;
    step(1'b1);
    check("restart_hv", {6'd0, d_h, 6'd0, d_v}, 32'd0);
    check("restart_fs", 32'(d_fs), 32'd1);
    step(1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
